// File: rtl/mux_pkg.sv
// Shared types and helpers for the round-robin stream mux and its arbiter.
package mux_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  // Index width for n items; never returns less than one bit.
  function automatic int clog2_safe(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, modulo NUM_CH.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = clog2_safe(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              grant_valid
);

  localparam logic [CH_W:0] NCH = (CH_W+1)'(NUM_CH);

  logic [CH_W:0]   sum_s;
  logic [CH_W-1:0] idx_s;

  // Walk channels ptr, ptr+1, ... with explicit wrap so non-power-of-two counts stay in range.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    sum_s       = '0;
    idx_s       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum_s = {1'b0, ptr} + (CH_W+1)'(k);
      if (sum_s >= NCH) begin
        idx_s = CH_W'(sum_s - NCH);
      end else begin
        idx_s = sum_s[CH_W-1:0];
      end
      if (!grant_valid && req[idx_s]) begin
        grant_valid = 1'b1;
        grant_idx   = idx_s;
      end else begin
        grant_valid = grant_valid;
      end
    end
    if (grant_valid) begin
      grant[grant_idx] = 1'b1;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel round-robin valid/ready stream mux with one registered output stage.
// Define RR_PKT_LOCK_EN to hold the grant on one channel until its in_last beat.
module rr_stream_mux
  import mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int CH_W   = clog2_safe(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     out_last,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     out_ready
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic [CH_W-1:0]   ptr_r;
  logic [CH_W-1:0]   ptr_nxt_s;
  logic [NUM_CH-1:0] req_s;
  logic [NUM_CH-1:0] grant_s;
  logic [CH_W-1:0]   grant_idx_s;
  logic              grant_valid_s;
  logic              load_s;
  logic              xfer_s;
  logic              ptr_adv_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              sel_last_s;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req         (req_s),
    .ptr         (ptr_r),
    .grant       (grant_s),
    .grant_idx   (grant_idx_s),
    .grant_valid (grant_valid_s)
  );

  // Reset gates load so no channel sees ready while the stage is being cleared.
  assign load_s    = (!out_valid || out_ready) && !rst;
  assign xfer_s    = load_s && grant_valid_s;
  assign in_ready  = {NUM_CH{load_s}} & grant_s;
  assign ptr_nxt_s = (grant_idx_s == LAST_CH) ? {CH_W{1'b0}} : grant_idx_s + CH_W'(1);

  // One-hot AND-OR select of the granted channel's data and last flag.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_data_s = sel_data_s | (in_data[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
    end
    sel_last_s = |(in_last & grant_s);
  end

`ifdef RR_PKT_LOCK_EN
  lock_state_t     state_r;
  logic [CH_W-1:0] lock_ch_r;

  // While locked only the owning channel may request; its gaps become bubbles.
  always_comb begin
    req_s = '0;
    if (state_r == LOCKED) begin
      req_s[lock_ch_r] = in_valid[lock_ch_r];
    end else begin
      req_s = in_valid;
    end
  end

  assign ptr_adv_s = xfer_s && sel_last_s;

  // Packet lock FSM: enter on a non-last beat, leave on the owner's last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      lock_ch_r <= '0;
    end else if (xfer_s) begin
      if (sel_last_s) begin
        state_r <= IDLE;
      end else begin
        state_r   <= LOCKED;
        lock_ch_r <= grant_idx_s;
      end
    end
  end
`else
  assign req_s     = in_valid;
  assign ptr_adv_s = xfer_s;
`endif

  // Priority pointer moves past the winner only when a grant is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (ptr_adv_s) begin
      ptr_r <= ptr_nxt_s;
    end
  end

  // Output stage: load on transfer, drop valid on an empty load, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else if (load_s) begin
      if (grant_valid_s) begin
        out_valid <= 1'b1;
        out_data  <= sel_data_s;
        out_last  <= sel_last_s;
        out_ch    <= grant_idx_s;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
